// File: rtl/picc_envelope_detector.sv
// picc_envelope_detector: rectify, integrate-and-dump and hysteresis-slice the PICC sample stream
// into one AXIS word {level, mean} per window.
module picc_envelope_detector #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int WINDOW_LOG2            = 4,
    parameter int THRESH_HI              = 2048,
    parameter int THRESH_LO              = 1024
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    input  logic [3:0]                        s00_axis_tstrb,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tlast,
    output logic [3:0]                        m00_axis_tstrb,
    output logic                              edge_out
);
    localparam int W  = C_S00_AXIS_TDATA_WIDTH;
    localparam int AW = W - 1 + WINDOW_LOG2;

    logic [AW-1:0]          acc;
    logic [WINDOW_LOG2-1:0] cnt;
    logic                   level;
    logic [W-1:0]           neg;
    logic [W-2:0]           mag;
    logic [AW-1:0]          sum;
    logic [AW-1:0]          mean;
    logic                   accept;
    logic                   dump;
    logic                   new_level;
    logic                   unused_tstrb;

    assign unused_tstrb = &{1'b0, s00_axis_tstrb};

    // Negating the most negative sample overflows back to itself; saturate it to full scale.
    assign neg       = -s00_axis_tdata;
    assign mag       = !s00_axis_tdata[W-1] ? s00_axis_tdata[W-2:0] :
                       neg[W-1] ? {(W-1){1'b1}} : neg[W-2:0];
    assign sum       = acc + AW'(mag);
    assign mean      = sum >> WINDOW_LOG2;
    assign accept    = s00_axis_tvalid & s00_axis_tready;
    assign dump      = accept & ((cnt == '1) | s00_axis_tlast);
    assign new_level = (mean > AW'(THRESH_HI)) ? 1'b1 :
                       (mean < AW'(THRESH_LO)) ? 1'b0 : level;

    assign s00_axis_tready = ~rst_in & (~m00_axis_tvalid | m00_axis_tready);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc             <= '0;
            cnt             <= '0;
            level           <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tstrb  <= 4'h0;
            edge_out        <= 1'b0;
        end else begin
            edge_out <= 1'b0;
            if (m00_axis_tvalid & m00_axis_tready) begin
                m00_axis_tvalid <= 1'b0;
                m00_axis_tlast  <= 1'b0;
                m00_axis_tstrb  <= 4'h0;
            end
            if (dump) begin
                acc             <= '0;
                cnt             <= '0;
                level           <= new_level;
                m00_axis_tvalid <= 1'b1;
                m00_axis_tdata  <= {new_level, mean[C_M00_AXIS_TDATA_WIDTH-2:0]};
                m00_axis_tlast  <= s00_axis_tlast;
                m00_axis_tstrb  <= 4'hF;
                edge_out        <= new_level != level;
            end else if (accept) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
